// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, default bus
// widths and the requester-select encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Which requester owns the memory port for the current grant.
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the requesters + memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_done;
    logic                  if_err;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_done;
    logic                  d_err;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
               mem_ready, mem_rdata,
        output if_done, if_err, if_rdata, d_done, d_err, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
               mem_ready, mem_rdata,
        input  if_done, if_err, if_rdata, d_done, d_err, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter. cnt holds the number of BUSY cycles already completed,
// so expired is high during the TIMEOUT-th BUSY cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT - 1));

    // Count enabled cycles, holding at the expiry value until cleared.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Data wins
// by default; fetch wins after MAX_D_STREAK consecutive data grants taken
// while it waited. A watchdog aborts accesses that never see mem_ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_e          state_q, state_d;
    logic [SW-1:0]       streak_q;
    logic                grant, sel, finish, timeout, expired;

    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wstrb_q;
    logic                if_done_q, if_err_q, d_done_q, d_err_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == IDLE),
        .en      (state_q != IDLE),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Arbitration and completion decode.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        sel     = SEL_D;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    grant = 1'b1;
                    if (bus.d_req && !(bus.if_req && streak_q == SW'(MAX_D_STREAK)))
                        sel = SEL_D;
                    else
                        sel = SEL_IF;
                    state_d = (sel == SEL_D) ? BUSY_D : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                // A ready in the expiry cycle still counts as success.
                if (bus.mem_ready) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side registers, fairness streak and completion reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            streak_q    <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            if_done_q <= 1'b0;
            if_err_q  <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            if (grant) begin
                mem_req_q <= 1'b1;
                if (sel == SEL_D) begin
                    mem_we_q    <= bus.d_we;
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                    mem_wstrb_q <= bus.d_wstrb;
                    if (!bus.if_req)
                        streak_q <= '0;
                    else if (streak_q != SW'(MAX_D_STREAK))
                        streak_q <= streak_q + 1'b1;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.if_addr;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                    streak_q    <= '0;
                end
            end
            if (finish) begin
                mem_req_q <= 1'b0;
                if (state_q == BUSY_IF) begin
                    if_done_q  <= 1'b1;
                    if_err_q   <= timeout;
                    if_rdata_q <= timeout ? '0 : bus.mem_rdata;
                end else begin
                    d_done_q <= 1'b1;
                    d_err_q  <= timeout;
                    if (timeout)
                        d_rdata_q <= '0;
                    else if (!mem_we_q)
                        d_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
